// File: rtl/issue_unit_pkg.sv
// Shared types for the issue stage: RS entry, dispatch packet, issue packet,
// FU class / operand-select encodings and RV32 immediate decoders.
package issue_unit_pkg;

    localparam int WORD_W = 32;
    localparam int ROB_W  = 5;
    localparam int TAG_W  = 6;
    localparam int FUNC_W = 5;

    typedef enum logic [2:0] {
        FU_ALU  = 3'd0,
        FU_MUL  = 3'd1,
        FU_LOAD = 3'd2,
        FU_BR   = 3'd3
    } fu_type_e;

    typedef enum logic [2:0] {
        OPA_RS1  = 3'd0,
        OPA_NPC  = 3'd1,
        OPA_PC   = 3'd2,
        OPA_ZERO = 3'd3
    } opa_select_e;

    typedef enum logic [2:0] {
        OPB_RS2 = 3'd0,
        OPB_I   = 3'd1,
        OPB_S   = 3'd2,
        OPB_B   = 3'd3,
        OPB_U   = 3'd4,
        OPB_J   = 3'd5
    } opb_select_e;

    typedef struct packed {
        logic [WORD_W-1:0] inst;
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] npc;
        logic [FUNC_W-1:0] alu_func;
        fu_type_e          fu_type;
        opa_select_e       opa_select;
        opb_select_e       opb_select;
    } disp_packet_t;

    typedef struct packed {
        disp_packet_t      disp_packet;
        logic [WORD_W-1:0] src1_tag;
        logic [WORD_W-1:0] src2_tag;
        logic [ROB_W-1:0]  rob_idx;
        logic [TAG_W-1:0]  dest_tag;
    } rs_entry_t;

    typedef struct packed {
        logic              valid;
        logic [FUNC_W-1:0] opcode;
        logic [WORD_W-1:0] src1_val;
        logic [WORD_W-1:0] src2_val;
        logic [WORD_W-1:0] imm;
        logic              src2_valid;
        logic [WORD_W-1:0] src1_mux;
        logic [WORD_W-1:0] src2_mux;
        logic [ROB_W-1:0]  rob_idx;
        fu_type_e          fu_type;
        logic [TAG_W-1:0]  dest_tag;
        disp_packet_t      disp_packet;
    } issue_packet_t;

    function automatic logic [31:0] imm_i(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:25], inst[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] inst);
        return {inst[31:12], 12'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/issue_unit_pkt_builder.sv
// Combinational operand mux and issue-packet formation for one RS entry.
module issue_pkt_builder
    import issue_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  rs_entry_t     entry,
    output issue_packet_t pkt
);

    logic [XLEN-1:0] src1_val;
    logic [XLEN-1:0] src2_val;
    logic            src2_valid;

    always_comb begin
        src1_val = 32'hdeadface;
        case (entry.disp_packet.opa_select)
            OPA_RS1:  src1_val = entry.src1_tag;
            OPA_NPC:  src1_val = entry.disp_packet.npc;
            OPA_PC:   src1_val = entry.disp_packet.pc;
            OPA_ZERO: src1_val = '0;
            default:  src1_val = 32'hdeadface;
        endcase

        // Immediate selects mark src2 as not-a-register so the FU skips bypass.
        src2_val   = 32'hfacefeed;
        src2_valid = 1'b1;
        case (entry.disp_packet.opb_select)
            OPB_RS2: src2_val = entry.src2_tag;
            OPB_I: begin src2_val = imm_i(entry.disp_packet.inst); src2_valid = 1'b0; end
            OPB_S: begin src2_val = imm_s(entry.disp_packet.inst); src2_valid = 1'b0; end
            OPB_B: begin src2_val = imm_b(entry.disp_packet.inst); src2_valid = 1'b0; end
            OPB_U: begin src2_val = imm_u(entry.disp_packet.inst); src2_valid = 1'b0; end
            OPB_J: begin src2_val = imm_j(entry.disp_packet.inst); src2_valid = 1'b0; end
            default: begin src2_val = 32'hfacefeed; src2_valid = 1'b1; end
        endcase

        pkt             = '0;
        pkt.valid       = 1'b1;
        pkt.opcode      = entry.disp_packet.alu_func;
        pkt.src1_val    = src1_val;
        pkt.src2_val    = src2_val;
        pkt.imm         = src2_val;
        pkt.src2_valid  = src2_valid;
        pkt.src1_mux    = entry.src1_tag;
        pkt.src2_mux    = entry.src2_tag;
        pkt.rob_idx     = entry.rob_idx;
        pkt.fu_type     = entry.disp_packet.fu_type;
        pkt.dest_tag    = entry.dest_tag;
        pkt.disp_packet = entry.disp_packet;
    end

endmodule

// File: rtl/issue_unit.sv
// Round-robin issue select from the RS into per-FU channel registers,
// bounded by ISSUE_WIDTH grants per cycle.
module issue_unit
    import issue_unit_pkg::*;
#(
    parameter int RS_DEPTH    = 16,
    parameter int ISSUE_WIDTH = 2,
    parameter int ALU_COUNT   = 2,
    parameter int MUL_COUNT   = 1,
    parameter int LOAD_COUNT  = 1,
    parameter int BR_COUNT    = 1,
    parameter int XLEN        = 32
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               flush_i,
    input  rs_entry_t                          rs_entries_i [RS_DEPTH],
    input  logic [RS_DEPTH-1:0]                rs_ready_i,
    output logic [RS_DEPTH-1:0]                issue_enable_o,
    input  logic [ALU_COUNT-1:0]               alu_ready_i,
    input  logic [MUL_COUNT-1:0]               mul_ready_i,
    input  logic [LOAD_COUNT-1:0]              load_ready_i,
    input  logic [BR_COUNT-1:0]                br_ready_i,
    output issue_packet_t                      alu_req_o  [ALU_COUNT],
    output issue_packet_t                      mul_req_o  [MUL_COUNT],
    output issue_packet_t                      load_req_o [LOAD_COUNT],
    output issue_packet_t                      br_req_o   [BR_COUNT],
    output logic [$clog2(ISSUE_WIDTH+1)-1:0]   issued_cnt_o
);

    localparam int NCH   = ALU_COUNT + MUL_COUNT + LOAD_COUNT + BR_COUNT;
    localparam int PTR_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
    localparam int CNT_W = $clog2(ISSUE_WIDTH + 1);

    // Channels are laid out ALU, MUL, LOAD, BR in one flat index space.
    function automatic fu_type_e chan_fu(input int c);
        if (c < ALU_COUNT) return FU_ALU;
        if (c < ALU_COUNT + MUL_COUNT) return FU_MUL;
        if (c < ALU_COUNT + MUL_COUNT + LOAD_COUNT) return FU_LOAD;
        return FU_BR;
    endfunction

    issue_packet_t    pkt_p0      [RS_DEPTH];
    issue_packet_t    chan_p1     [NCH];
    logic [PTR_W-1:0] chan_src_p0 [NCH];
    logic [NCH-1:0]   chan_ready;
    logic [NCH-1:0]   chan_free;
    logic [NCH-1:0]   chan_take_p0;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] last_grant;
    logic             any_grant;
    logic             placed;
    int               grants;
    int               scan_idx;

    assign chan_ready = {br_ready_i, load_ready_i, mul_ready_i, alu_ready_i};

    for (genvar r = 0; r < RS_DEPTH; r++) begin : g_build
        issue_pkt_builder #(.XLEN(XLEN)) u_build (
            .entry (rs_entries_i[r]),
            .pkt   (pkt_p0[r])
        );
    end

    // Stage p0: grant selection, combinational in the grant cycle.
    always_comb begin
        issue_enable_o = '0;
        chan_take_p0   = '0;
        grants         = 0;
        last_grant     = rr_ptr;
        any_grant      = 1'b0;
        placed         = 1'b0;
        scan_idx       = 0;
        for (int c = 0; c < NCH; c++) begin
            chan_src_p0[c] = '0;
            chan_free[c]   = !chan_p1[c].valid || chan_ready[c];
        end
        if (!reset && !flush_i) begin
            for (int k = 0; k < RS_DEPTH; k++) begin
                scan_idx = int'(rr_ptr) + k;
                if (scan_idx >= RS_DEPTH) scan_idx = scan_idx - RS_DEPTH;
                placed = 1'b0;
                if (rs_ready_i[scan_idx] && grants < ISSUE_WIDTH) begin
                    for (int c = 0; c < NCH; c++) begin
                        if (!placed && chan_free[c] && !chan_take_p0[c] &&
                            chan_fu(c) == rs_entries_i[scan_idx].disp_packet.fu_type) begin
                            chan_take_p0[c] = 1'b1;
                            chan_src_p0[c]  = PTR_W'(scan_idx);
                            placed          = 1'b1;
                        end
                    end
                end
                if (placed) begin
                    issue_enable_o[scan_idx] = 1'b1;
                    grants     = grants + 1;
                    last_grant = PTR_W'(scan_idx);
                    any_grant  = 1'b1;
                end
            end
        end
        issued_cnt_o = CNT_W'(grants);
    end

    // Stage p1: channel registers and round-robin pointer.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr <= '0;
            for (int c = 0; c < NCH; c++) chan_p1[c] <= '0;
        end else if (flush_i) begin
            for (int c = 0; c < NCH; c++) chan_p1[c] <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (chan_take_p0[c])
                    chan_p1[c] <= pkt_p0[chan_src_p0[c]];
                else if (chan_p1[c].valid && chan_ready[c])
                    chan_p1[c].valid <= 1'b0;
            end
            if (any_grant)
                rr_ptr <= (int'(last_grant) == RS_DEPTH - 1) ? '0 : last_grant + 1'b1;
        end
    end

    for (genvar a = 0; a < ALU_COUNT; a++) begin : g_alu
        assign alu_req_o[a] = chan_p1[a];
    end
    for (genvar m = 0; m < MUL_COUNT; m++) begin : g_mul
        assign mul_req_o[m] = chan_p1[ALU_COUNT + m];
    end
    for (genvar l = 0; l < LOAD_COUNT; l++) begin : g_load
        assign load_req_o[l] = chan_p1[ALU_COUNT + MUL_COUNT + l];
    end
    for (genvar b = 0; b < BR_COUNT; b++) begin : g_br
        assign br_req_o[b] = chan_p1[ALU_COUNT + MUL_COUNT + LOAD_COUNT + b];
    end

endmodule

// File: tb/tb_issue_unit.sv
// Directed scenarios followed by random traffic, checked against a
// behavioural model of grant selection and channel occupancy.
module tb_issue_unit;
    import issue_unit_pkg::*;

    localparam int RS  = 16;
    localparam int NCH = 5;

    logic          clock = 1'b0;
    logic          reset;
    logic          flush;
    rs_entry_t     entries [RS];
    logic [RS-1:0] rs_ready;
    logic [RS-1:0] issue_enable;
    logic [1:0]    alu_ready;
    logic          mul_ready, load_ready, br_ready;
    issue_packet_t alu_req [2];
    issue_packet_t mul_req [1];
    issue_packet_t load_req [1];
    issue_packet_t br_req [1];
    logic [1:0]    issued_cnt;

    int tests = 0;
    int fails = 0;

    issue_packet_t  exp_ch [NCH];
    issue_packet_t  nxt_ch [NCH];
    logic [NCH-1:0] full_chk, nxt_full;
    int             exp_rr, nxt_rr, exp_cnt;
    logic [RS-1:0]  exp_en;

    always #5 clock = ~clock;

    issue_unit dut (
        .clock          (clock),
        .reset          (reset),
        .flush_i        (flush),
        .rs_entries_i   (entries),
        .rs_ready_i     (rs_ready),
        .issue_enable_o (issue_enable),
        .alu_ready_i    (alu_ready),
        .mul_ready_i    (mul_ready),
        .load_ready_i   (load_ready),
        .br_ready_i     (br_ready),
        .alu_req_o      (alu_req),
        .mul_req_o      (mul_req),
        .load_req_o     (load_req),
        .br_req_o       (br_req),
        .issued_cnt_o   (issued_cnt)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int chan_class(input int c);
        return (c < 2) ? 0 : c - 1;
    endfunction

    function automatic logic chan_rdy(input int c);
        case (c)
            0: return alu_ready[0];
            1: return alu_ready[1];
            2: return mul_ready;
            3: return load_ready;
            default: return br_ready;
        endcase
    endfunction

    function automatic issue_packet_t dut_ch(input int c);
        case (c)
            0: return alu_req[0];
            1: return alu_req[1];
            2: return mul_req[0];
            3: return load_req[0];
            default: return br_req[0];
        endcase
    endfunction

    // Packet contents written from the ISA definition of each immediate.
    function automatic issue_packet_t model_pkt(input rs_entry_t e);
        issue_packet_t      p;
        logic [31:0]        in, a, b;
        logic signed [31:0] s;
        logic               v;
        in = e.disp_packet.inst;
        s  = $signed(in);
        case (int'(e.disp_packet.opa_select))
            0: a = e.src1_tag;
            1: a = e.disp_packet.npc;
            2: a = e.disp_packet.pc;
            3: a = 32'h0;
            default: a = 32'hdeadface;
        endcase
        v = 1'b0;
        case (int'(e.disp_packet.opb_select))
            0: begin b = e.src2_tag; v = 1'b1; end
            1: b = 32'(s >>> 20);
            2: b = (32'(s >>> 20) & ~32'h1f) | {27'b0, in[11:7]};
            3: b = (32'(s >>> 19) & 32'hfffff000) | {20'b0, in[7], in[30:25], in[11:8], 1'b0};
            4: b = in & 32'hfffff000;
            5: b = (32'(s >>> 11) & 32'hfff00000) | (in & 32'h000ff000) | {20'b0, in[20], in[30:21], 1'b0};
            default: begin b = 32'hfacefeed; v = 1'b1; end
        endcase
        p             = '0;
        p.valid       = 1'b1;
        p.opcode      = e.disp_packet.alu_func;
        p.src1_val    = a;
        p.src2_val    = b;
        p.imm         = b;
        p.src2_valid  = v;
        p.src1_mux    = e.src1_tag;
        p.src2_mux    = e.src2_tag;
        p.rob_idx     = e.rob_idx;
        p.fu_type     = e.disp_packet.fu_type;
        p.dest_tag    = e.dest_tag;
        p.disp_packet = e.disp_packet;
        return p;
    endfunction

    // The j-th free channel of class k (lowest index first), or -1.
    function automatic int nth_free(input int k, input int j);
        int n = 0;
        for (int c = 0; c < NCH; c++) begin
            if (chan_class(c) == k && (!exp_ch[c].valid || chan_rdy(c))) begin
                if (n == j) return c;
                n++;
            end
        end
        return -1;
    endfunction

    task automatic model_cycle();
        int g [4];
        int last, e, f, ch;
        exp_en  = '0;
        exp_cnt = 0;
        nxt_rr  = exp_rr;
        for (int c = 0; c < NCH; c++) begin
            nxt_ch[c]   = exp_ch[c];
            nxt_full[c] = full_chk[c];
            if (exp_ch[c].valid && chan_rdy(c)) begin
                nxt_ch[c].valid = 1'b0;
                nxt_full[c]     = 1'b0;
            end
        end
        if (reset || flush) begin
            for (int c = 0; c < NCH; c++) nxt_ch[c] = '0;
            nxt_full = '1;
            if (reset) nxt_rr = 0;
        end else begin
            g    = '{0, 0, 0, 0};
            last = -1;
            for (int k = 0; k < RS; k++) begin
                e = (exp_rr + k) % RS;
                f = int'(entries[e].disp_packet.fu_type);
                if (rs_ready[e] && exp_cnt < 2 && f < 4) begin
                    ch = nth_free(f, g[f]);
                    if (ch >= 0) begin
                        g[f]++;
                        exp_cnt++;
                        exp_en[e]    = 1'b1;
                        nxt_ch[ch]   = model_pkt(entries[e]);
                        nxt_full[ch] = 1'b1;
                        last         = e;
                    end
                end
            end
            if (last >= 0) nxt_rr = (last + 1) % RS;
        end
    endtask

    task automatic step_pre();
        #1;
        model_cycle();
        chk("issue_enable", 512'(issue_enable), 512'(exp_en));
        chk("issued_cnt", 512'(issued_cnt), 512'(exp_cnt));
    endtask

    task automatic step_post();
        @(posedge clock);
        #1;
        exp_ch   = nxt_ch;
        full_chk = nxt_full;
        exp_rr   = nxt_rr;
        rs_ready = rs_ready & ~exp_en;
        for (int c = 0; c < NCH; c++) begin
            if (full_chk[c])
                chk($sformatf("chan%0d", c), 512'(dut_ch(c)), 512'(exp_ch[c]));
            else
                chk($sformatf("chan%0d_valid", c), 512'(dut_ch(c).valid), 512'(exp_ch[c].valid));
        end
        @(negedge clock);
    endtask

    task automatic step();
        step_pre();
        step_post();
    endtask

    function automatic rs_entry_t rand_entry();
        rs_entry_t e;
        int        r;
        e.disp_packet.inst       = $urandom;
        e.disp_packet.pc         = $urandom;
        e.disp_packet.npc        = $urandom;
        e.disp_packet.alu_func   = 5'($urandom);
        r                        = $urandom_range(0, 9);
        e.disp_packet.fu_type    = fu_type_e'(3'((r < 8) ? (r % 4) : (4 + r % 4)));
        e.disp_packet.opa_select = opa_select_e'(3'($urandom_range(0, 7)));
        e.disp_packet.opb_select = opb_select_e'(3'($urandom_range(0, 7)));
        e.src1_tag               = $urandom;
        e.src2_tag               = $urandom;
        e.rob_idx                = 5'($urandom);
        e.dest_tag               = 6'($urandom);
        return e;
    endfunction

    function automatic logic [4:0] rob_of(input int idx);
        return 5'(idx + 10);
    endfunction

    task automatic put(input int idx, input fu_type_e fu, input logic [31:0] inst, input opb_select_e opb);
        entries[idx]                        = rand_entry();
        entries[idx].disp_packet.fu_type    = fu;
        entries[idx].disp_packet.inst       = inst;
        entries[idx].disp_packet.opb_select = opb;
        entries[idx].rob_idx                = rob_of(idx);
        rs_ready[idx]                       = 1'b1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; rs_ready = '0;
        alu_ready = 2'b11; mul_ready = 1'b1; load_ready = 1'b1; br_ready = 1'b1;
        for (int i = 0; i < RS; i++) entries[i] = rand_entry();
        for (int c = 0; c < NCH; c++) exp_ch[c] = '0;
        full_chk = '1;
        exp_rr   = 0;
        @(negedge clock);

        // Reset state with ready entries present.
        put(0, FU_ALU, $urandom, OPB_RS2);
        step_pre();
        chk("reset_en", 512'(issue_enable), 512'(0));
        step_post();
        reset = 1'b0;
        rs_ready = '0;

        // ALU entries 3, 5, 9 from rr_ptr 0.
        put(3, FU_ALU, $urandom, OPB_RS2);
        put(5, FU_ALU, $urandom, OPB_RS2);
        put(9, FU_ALU, $urandom, OPB_RS2);
        step_pre();
        chk("rr_en_3_5", 512'(issue_enable), 512'(16'h0028));
        step_post();
        chk("alu0_rob", 512'(alu_req[0].rob_idx), 512'(rob_of(3)));
        chk("alu1_rob", 512'(alu_req[1].rob_idx), 512'(rob_of(5)));
        step();

        // Immediate forms.
        put(4, FU_ALU, 32'hffc00013, OPB_I);
        step();
        chk("addi_src2", 512'(alu_req[0].src2_val), 512'(32'hfffffffc));
        chk("addi_imm", 512'(alu_req[0].imm), 512'(32'hfffffffc));
        chk("addi_src2_valid", 512'(alu_req[0].src2_valid), 512'(0));
        put(7, FU_ALU, 32'h12345037, OPB_U);
        step();
        chk("lui_src2", 512'(alu_req[0].src2_val), 512'(32'h12345000));

        // MUL stall: held packet, then new grant in the ready cycle.
        mul_ready = 1'b0;
        put(2, FU_MUL, $urandom, OPB_RS2);
        step();
        put(8, FU_MUL, $urandom, OPB_RS2);
        for (int i = 0; i < 3; i++) begin
            step_pre();
            chk("mul_hold_en", 512'(issue_enable), 512'(0));
            step_post();
            chk("mul_hold_rob", 512'(mul_req[0].rob_idx), 512'(rob_of(2)));
        end
        mul_ready = 1'b1;
        step_pre();
        chk("mul_release_en", 512'(issue_enable), 512'(16'h0100));
        step_post();
        chk("mul_new_rob", 512'(mul_req[0].rob_idx), 512'(rob_of(8)));

        // Wrap-around: walk rr_ptr to 14, then entries 15 and 1.
        put(13, FU_ALU, $urandom, OPB_RS2);
        step();
        put(1, FU_ALU, $urandom, OPB_RS2);
        put(15, FU_ALU, $urandom, OPB_RS2);
        step_pre();
        chk("wrap_en", 512'(issue_enable), 512'(16'h8002));
        step_post();
        put(0, FU_ALU, $urandom, OPB_RS2);
        put(2, FU_ALU, $urandom, OPB_RS2);
        put(3, FU_ALU, $urandom, OPB_RS2);
        step_pre();
        chk("wrap_rr2_en", 512'(issue_enable), 512'(16'h000c));
        step_post();
        rs_ready = '0;

        // Flush with every channel valid and stalled.
        alu_ready = 2'b00; mul_ready = 1'b0; load_ready = 1'b0; br_ready = 1'b0;
        put(5, FU_MUL, $urandom, OPB_RS2);
        put(6, FU_LOAD, $urandom, OPB_RS2);
        step();
        put(7, FU_BR, $urandom, OPB_RS2);
        step();
        put(9, FU_ALU, $urandom, OPB_RS2);
        put(10, FU_MUL, $urandom, OPB_RS2);
        flush = 1'b1;
        step_pre();
        chk("flush_en", 512'(issue_enable), 512'(0));
        step_post();
        flush = 1'b0;
        for (int c = 0; c < NCH; c++) chk("flush_valid", 512'(dut_ch(c).valid), 512'(0));
        rs_ready = '0;

        // Reset in the middle of a stall.
        put(11, FU_ALU, $urandom, OPB_RS2);
        put(12, FU_ALU, $urandom, OPB_RS2);
        step();
        put(13, FU_MUL, $urandom, OPB_RS2);
        put(4, FU_BR, $urandom, OPB_RS2);
        step();
        put(14, FU_LOAD, $urandom, OPB_RS2);
        step();
        put(1, FU_ALU, $urandom, OPB_RS2);
        reset = 1'b1;
        step_pre();
        chk("stall_reset_cnt", 512'(issued_cnt), 512'(0));
        step_post();
        reset = 1'b0;
        for (int c = 0; c < NCH; c++) chk("stall_reset_zero", 512'(dut_ch(c)), 512'(0));
        alu_ready = 2'b11; mul_ready = 1'b1; load_ready = 1'b1; br_ready = 1'b1;
        rs_ready = '0;
        put(1, FU_ALU, $urandom, OPB_RS2);
        put(2, FU_ALU, $urandom, OPB_RS2);
        put(15, FU_ALU, $urandom, OPB_RS2);
        step_pre();
        chk("post_reset_rr0", 512'(issue_enable), 512'(16'h0006));
        step_post();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < RS; i++) entries[i] = rand_entry();
            rs_ready   = RS'($urandom);
            alu_ready  = 2'($urandom_range(0, 9) < 7 ? 3 : $urandom_range(0, 3));
            mul_ready  = ($urandom_range(0, 9) < 6);
            load_ready = ($urandom_range(0, 9) < 6);
            br_ready   = ($urandom_range(0, 9) < 6);
            reset      = ($urandom_range(0, 63) == 0);
            flush      = ($urandom_range(0, 31) == 0);
            step();
        end
        reset = 1'b0;
        flush = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
